bw_r_irf_swap_ctl: RTL and testbench

BW_R_IRF_SWAP_CTL -- requirements
Module: bw_r_irf_swap_ctl

---
 rtl/bw_r_irf_pkg.sv | 44 ++++
 rtl/bw_r_irf_swap_rr_arb.sv | 32 +++
 rtl/bw_r_irf_swap_ctl.sv | 165 ++++++++++++++++
 tb/tb_bw_r_irf_swap_ctl.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bw_r_irf_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : bw_r_irf_pkg
//  Brief    : Shared state encoding, request kinds and helpers for the IRF
//             window-swap controller.
//  Revision : 1.0  initial release
// ============================================================================
package bw_r_irf_pkg;

    localparam int c_NTHR  = 4;
    localparam int c_TID_W = 2;
    localparam int c_CWP_W = 3;

    localparam logic [1:0] c_KIND_NOP     = 2'b00;
    localparam logic [1:0] c_KIND_SAVE    = 2'b01;
    localparam logic [1:0] c_KIND_RESTORE = 2'b10;
    localparam logic [1:0] c_KIND_SWAP    = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SAVE    = 3'd1,
        ST_GAP     = 3'd2,
        ST_RESTORE = 3'd3,
        ST_DONE    = 3'd4
    } swap_state_t;

    function automatic logic [c_NTHR-1:0] tid_onehot(input logic [c_TID_W-1:0] tid);
        logic [c_NTHR-1:0] v;
        v      = '0;
        v[tid] = 1'b1;
        return v;
    endfunction

    // A swap into the window already being saved needs no restore.
    function automatic logic [1:0] eff_kind(input logic [1:0]         kind,
                                            input logic [c_CWP_W-1:0] old_cwp,
                                            input logic [c_CWP_W-1:0] new_cwp);
        if (kind == c_KIND_SWAP && old_cwp == new_cwp)
            return c_KIND_SAVE;
        return kind;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bw_r_irf_swap_rr_arb.sv
`default_nettype none
// ============================================================================
//  Module   : bw_r_irf_swap_rr_arb
//  Brief    : Round-robin thread picker; search starts at the thread after ptr.
//  Revision : 1.0  initial release
// ============================================================================
module bw_r_irf_swap_rr_arb
    import bw_r_irf_pkg::*;
(
    input  logic [3:0] pending,
    input  logic [1:0] ptr,
    output logic       grant_vld,
    output logic [1:0] grant_tid
);

    logic [1:0] w_idx;

    always_comb begin
        grant_vld = 1'b0;
        grant_tid = ptr;
        w_idx     = ptr;
        for (int i = 1; i <= c_NTHR; i++) begin
            w_idx = ptr + 2'(i);
            if (!grant_vld && pending[w_idx]) begin
                grant_vld = 1'b1;
                grant_tid = w_idx;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/bw_r_irf_swap_ctl.sv
`default_nettype none
// ============================================================================
//  Module   : bw_r_irf_swap_ctl
//  Brief    : Per-thread register-window save/restore sequencer for the IRF.
//  Revision : 1.0  initial release
// ============================================================================
module bw_r_irf_swap_ctl
    import bw_r_irf_pkg::*;
#(
    parameter int NTHR = c_NTHR
)(
    input  logic             clk,
    input  logic             reset,
    input  logic             req_vld,
    output logic             req_rdy,
    input  logic [1:0]       req_tid,
    input  logic [1:0]       req_kind,
    input  logic [2:0]       req_old_cwp,
    input  logic [2:0]       req_new_cwp,
    output logic             save,
    output logic [4:0]       save_addr,
    output logic             restore,
    output logic [4:0]       restore_addr,
    output logic [NTHR-1:0]  tid_stall,
    output logic             swap_done,
    output logic [1:0]       done_tid
);

    swap_state_t             r_state;
    logic [NTHR-1:0]         r_pending;
    logic [c_TID_W-1:0]      r_ptr;
    logic [c_TID_W-1:0]      r_cur_tid;
    logic [1:0]              r_cur_kind;
    logic                    r_save;
    logic                    r_restore;
    logic                    r_swap_done;
    logic [c_TID_W-1:0]      r_done_tid;
    logic [NTHR-1:0]         r_tid_stall;
    logic [4:0]              r_save_addr;
    logic [4:0]              r_restore_addr;

    logic [1:0]              r_slot_kind [NTHR];
    logic [c_CWP_W-1:0]      r_slot_old  [NTHR];
    logic [c_CWP_W-1:0]      r_slot_new  [NTHR];

    logic                    w_hs;
    logic [NTHR-1:0]         w_set_mask;
    logic [NTHR-1:0]         w_clr_mask;
    logic                    w_grant_vld;
    logic [c_TID_W-1:0]      w_grant_tid;
    logic [1:0]              w_grant_kind;

    assign req_rdy    = ~reset & ~r_pending[req_tid];
    assign w_hs       = req_vld & req_rdy;
    assign w_set_mask = w_hs ? tid_onehot(req_tid) : '0;
    // The slot frees only at the DONE edge, so a same-thread retry waits a cycle.
    assign w_clr_mask = (r_state == ST_DONE) ? tid_onehot(r_cur_tid) : '0;

    assign w_grant_kind = eff_kind(r_slot_kind[w_grant_tid],
                                   r_slot_old[w_grant_tid],
                                   r_slot_new[w_grant_tid]);

    bw_r_irf_swap_rr_arb u_arb (
        .pending   (r_pending),
        .ptr       (r_ptr),
        .grant_vld (w_grant_vld),
        .grant_tid (w_grant_tid)
    );

    always_ff @(posedge clk) begin
        if (w_hs) begin
            r_slot_kind[req_tid] <= req_kind;
            r_slot_old[req_tid]  <= req_old_cwp;
            r_slot_new[req_tid]  <= req_new_cwp;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= ST_IDLE;
            r_pending      <= '0;
            r_ptr          <= 2'd3;
            r_cur_tid      <= '0;
            r_cur_kind     <= c_KIND_NOP;
            r_save         <= 1'b0;
            r_restore      <= 1'b0;
            r_swap_done    <= 1'b0;
            r_done_tid     <= '0;
            r_tid_stall    <= '0;
            r_save_addr    <= '0;
            r_restore_addr <= '0;
        end else begin
            r_pending   <= (r_pending & ~w_clr_mask) | w_set_mask;
            r_save      <= 1'b0;
            r_restore   <= 1'b0;
            r_swap_done <= 1'b0;
            r_tid_stall <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (w_grant_vld) begin
                        r_cur_tid      <= w_grant_tid;
                        r_ptr          <= w_grant_tid;
                        r_cur_kind     <= w_grant_kind;
                        r_save_addr    <= {w_grant_tid, r_slot_old[w_grant_tid]};
                        r_restore_addr <= {w_grant_tid, r_slot_new[w_grant_tid]};
                        case (w_grant_kind)
                            c_KIND_SWAP, c_KIND_SAVE: begin
                                r_state     <= ST_SAVE;
                                r_save      <= 1'b1;
                                r_tid_stall <= tid_onehot(w_grant_tid);
                            end
                            c_KIND_RESTORE: begin
                                r_state     <= ST_RESTORE;
                                r_restore   <= 1'b1;
                                r_tid_stall <= tid_onehot(w_grant_tid);
                            end
                            default: begin
                                r_state     <= ST_DONE;
                                r_swap_done <= 1'b1;
                                r_done_tid  <= w_grant_tid;
                            end
                        endcase
                    end
                end
                ST_SAVE: begin
                    if (r_cur_kind == c_KIND_SWAP) begin
                        // Idle cycle lets the array finish its negedge window write.
                        r_state     <= ST_GAP;
                        r_tid_stall <= tid_onehot(r_cur_tid);
                    end else begin
                        r_state     <= ST_DONE;
                        r_swap_done <= 1'b1;
                        r_done_tid  <= r_cur_tid;
                    end
                end
                ST_GAP: begin
                    r_state     <= ST_RESTORE;
                    r_restore   <= 1'b1;
                    r_tid_stall <= tid_onehot(r_cur_tid);
                end
                ST_RESTORE: begin
                    r_state     <= ST_DONE;
                    r_swap_done <= 1'b1;
                    r_done_tid  <= r_cur_tid;
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign save         = r_save;
    assign restore      = r_restore;
    assign swap_done    = r_swap_done;
    assign done_tid     = r_done_tid;
    assign tid_stall    = r_tid_stall;
    assign save_addr    = r_save_addr;
    assign restore_addr = r_restore_addr;

endmodule
`default_nettype wire

// File: tb/tb_bw_r_irf_swap_ctl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bw_r_irf_swap_ctl
//  Brief    : Directed bench with a timeline model of the swap controller.
//  Revision : 1.0  initial release
// ============================================================================
module tb_bw_r_irf_swap_ctl;

    logic       clk;
    logic       reset;
    logic       req_vld;
    logic       req_rdy;
    logic [1:0] req_tid;
    logic [1:0] req_kind;
    logic [2:0] req_old_cwp;
    logic [2:0] req_new_cwp;
    logic       save;
    logic [4:0] save_addr;
    logic       restore;
    logic [4:0] restore_addr;
    logic [3:0] tid_stall;
    logic       swap_done;
    logic [1:0] done_tid;

    int checks = 0;
    int errors = 0;

    bw_r_irf_swap_ctl #(.NTHR(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_vld      (req_vld),
        .req_rdy      (req_rdy),
        .req_tid      (req_tid),
        .req_kind     (req_kind),
        .req_old_cwp  (req_old_cwp),
        .req_new_cwp  (req_new_cwp),
        .save         (save),
        .save_addr    (save_addr),
        .restore      (restore),
        .restore_addr (restore_addr),
        .tid_stall    (tid_stall),
        .swap_done    (swap_done),
        .done_tid     (done_tid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: each cycle is a record of what the outputs must show; a grant
    // appends the whole sequence for that request kind.
    typedef struct packed {
        logic       busy;
        logic       sv;
        logic       rs;
        logic       dn;
        logic [3:0] stall;
        logic [1:0] tid;
    } rec_t;

    function automatic rec_t mk(input logic s, input logic r, input logic d,
                                input logic [3:0] st, input logic [1:0] t);
        rec_t x;
        x.busy = 1'b1; x.sv = s; x.rs = r; x.dn = d; x.stall = st; x.tid = t;
        return x;
    endfunction

    rec_t       m_q[$];
    rec_t       m_now;
    logic [3:0] m_pend;
    int         m_ptr;
    logic [4:0] m_sa, m_ra;
    logic [1:0] s_kind [4];
    logic [2:0] s_old  [4];
    logic [2:0] s_new  [4];
    logic       m_valid = 1'b0;
    logic [1:0] done_log[$];

    always @(posedge clk) begin : model
        logic [3:0] pb;
        int         g;
        logic [1:0] k;
        logic [3:0] oh;
        if (reset) begin
            m_q.delete();
            m_now   = '0;
            m_pend  = '0;
            m_ptr   = 3;
            m_sa    = '0;
            m_ra    = '0;
            m_valid = 1'b1;
        end else if (m_valid) begin
            pb = m_pend;
            if (m_now.dn) m_pend[m_now.tid] = 1'b0;
            if (req_vld && !pb[req_tid]) begin
                m_pend[req_tid] = 1'b1;
                s_kind[req_tid] = req_kind;
                s_old[req_tid]  = req_old_cwp;
                s_new[req_tid]  = req_new_cwp;
            end
            if (!m_now.busy && m_q.size() == 0 && pb != 4'd0) begin
                g = -1;
                for (int j = 1; j <= 4; j++)
                    if (g < 0 && pb[(m_ptr + j) % 4]) g = (m_ptr + j) % 4;
                m_ptr = g;
                m_sa  = {g[1:0], s_old[g]};
                m_ra  = {g[1:0], s_new[g]};
                oh    = 4'b0001 << g;
                k     = s_kind[g];
                if (k == 2'b11 && s_old[g] == s_new[g]) k = 2'b01;
                case (k)
                    2'b11: begin
                        m_q.push_back(mk(1, 0, 0, oh, g[1:0]));
                        m_q.push_back(mk(0, 0, 0, oh, g[1:0]));
                        m_q.push_back(mk(0, 1, 0, oh, g[1:0]));
                    end
                    2'b01: m_q.push_back(mk(1, 0, 0, oh, g[1:0]));
                    2'b10: m_q.push_back(mk(0, 1, 0, oh, g[1:0]));
                    default: ;
                endcase
                m_q.push_back(mk(0, 0, 1, 4'd0, g[1:0]));
            end
            m_now = (m_q.size() > 0) ? m_q.pop_front() : rec_t'('0);
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("req_rdy", req_rdy, !reset && !m_pend[req_tid]);
            chk("save", save, m_now.sv);
            chk("restore", restore, m_now.rs);
            chk("swap_done", swap_done, m_now.dn);
            chk("tid_stall", tid_stall, m_now.stall);
            chk("save_addr", save_addr, m_sa);
            chk("restore_addr", restore_addr, m_ra);
            if (m_now.dn) chk("done_tid", done_tid, m_now.tid);
            if (swap_done) done_log.push_back(done_tid);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] t, input logic [1:0] k,
                         input logic [2:0] o, input logic [2:0] n);
        req_vld     = 1'b1;
        req_tid     = t;
        req_kind    = k;
        req_old_cwp = o;
        req_new_cwp = n;
    endtask

    initial begin
        reset = 1'b1; req_vld = 1'b0; req_tid = '0; req_kind = '0;
        req_old_cwp = '0; req_new_cwp = '0;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk("lit_rst_rdy", req_rdy, 0);
        chk("lit_rst_save_addr", save_addr, 0);
        chk("lit_rst_stall", tid_stall, 0);
        chk("lit_rst_done", swap_done, 0);
        step(); reset = 1'b0;
        @(negedge clk); chk("lit_rdy_after_rst", req_rdy, 1);

        // tid 2 swap, old 5 -> new 1
        step(); drive(2, 2'b11, 3'd5, 3'd1);
        @(negedge clk); chk("lit_s1_rdy", req_rdy, 1);
        step(); req_vld = 1'b0;
        @(negedge clk); chk("lit_s1_c1_save", save, 0); chk("lit_s1_c1_stall", tid_stall, 0);
        step(); @(negedge clk);
        chk("lit_s1_c2_save", save, 1); chk("lit_s1_c2_addr", save_addr, 5'h15);
        chk("lit_s1_c2_stall", tid_stall, 4'b0100);
        step(); @(negedge clk);
        chk("lit_s1_gap_save", save, 0); chk("lit_s1_gap_restore", restore, 0);
        chk("lit_s1_gap_stall", tid_stall, 4'b0100);
        step(); @(negedge clk);
        chk("lit_s1_c4_restore", restore, 1); chk("lit_s1_c4_addr", restore_addr, 5'h11);
        chk("lit_s1_c4_stall", tid_stall, 4'b0100);
        step(); @(negedge clk);
        chk("lit_s1_c5_done", swap_done, 1); chk("lit_s1_c5_tid", done_tid, 2);
        chk("lit_s1_c5_stall", tid_stall, 0);
        step(); @(negedge clk); chk("lit_s1_c6_done", swap_done, 0);

        // tid 1 swap with equal windows -> save only
        step(); drive(1, 2'b11, 3'd3, 3'd3);
        step(); req_vld = 1'b0;
        step(); @(negedge clk);
        chk("lit_s2_save", save, 1); chk("lit_s2_addr", save_addr, 5'h0B);
        chk("lit_s2_restore", restore, 0);
        step(); @(negedge clk);
        chk("lit_s2_done", swap_done, 1); chk("lit_s2_tid", done_tid, 1);
        chk("lit_s2_restore_d", restore, 0);

        // three threads back to back
        step(); done_log.delete();
        drive(0, 2'b11, 3'd1, 3'd2);
        step(); drive(1, 2'b11, 3'd2, 3'd4);
        step(); drive(3, 2'b10, 3'd0, 3'd6);
        step(); req_vld = 1'b0;
        repeat (20) step();
        chk("lit_s3_count", done_log.size(), 3);
        if (done_log.size() == 3) begin
            chk("lit_s3_first", done_log[0], 0);
            chk("lit_s3_second", done_log[1], 1);
            chk("lit_s3_third", done_log[2], 3);
        end

        // repeat tid 0 while its swap is outstanding
        step(); drive(0, 2'b11, 3'd7, 3'd0);
        @(negedge clk); chk("lit_s4_c0_rdy", req_rdy, 1);
        step(); req_kind = 2'b10; req_new_cwp = 3'd4;
        @(negedge clk); chk("lit_s4_c1_rdy", req_rdy, 0);
        for (int c = 2; c <= 5; c++) begin
            step(); @(negedge clk); chk("lit_s4_blocked_rdy", req_rdy, 0);
        end
        chk("lit_s4_c5_done", swap_done, 1);
        step(); @(negedge clk); chk("lit_s4_c6_rdy", req_rdy, 1);
        step(); req_vld = 1'b0;
        repeat (12) step();

        // reset during GAP aborts the swap
        drive(2, 2'b11, 3'd6, 3'd2);
        step(); req_vld = 1'b0;
        step(); @(negedge clk); chk("lit_s5_save", save, 1);
        step(); reset = 1'b1;
        @(negedge clk); chk("lit_s5_rst_rdy", req_rdy, 0); chk("lit_s5_gap_restore", restore, 0);
        step(); reset = 1'b0;
        @(negedge clk);
        chk("lit_s5_restore", restore, 0); chk("lit_s5_done", swap_done, 0);
        chk("lit_s5_stall", tid_stall, 0); chk("lit_s5_sa", save_addr, 0);
        chk("lit_s5_ra", restore_addr, 0); chk("lit_s5_rdy_tid2", req_rdy, 1);
        for (int c = 0; c < 5; c++) begin
            step(); @(negedge clk);
            chk("lit_s5_no_restore", restore, 0); chk("lit_s5_no_done", swap_done, 0);
        end

        // kind 00 for tid 3
        step(); drive(3, 2'b00, 3'd1, 3'd2);
        step(); req_vld = 1'b0;
        @(negedge clk); chk("lit_s6_c1_save", save, 0); chk("lit_s6_c1_restore", restore, 0);
        step(); @(negedge clk);
        chk("lit_s6_done", swap_done, 1); chk("lit_s6_tid", done_tid, 3);
        chk("lit_s6_save", save, 0); chk("lit_s6_restore", restore, 0);
        step(); @(negedge clk); chk("lit_s6_done_off", swap_done, 0);
        repeat (3) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
